kmp_stream_matcher: RTL and testbench
=====================================

# kmp_stream_matcher

Parametrised Knuth-Morris-Pratt string-search engine: the next-generation replacement for the fixed-size KMP path of the search top level. A pattern of up to MAX_PAT symbols is written into an internal table. On start, the block builds the prefix (failure) table sequentially, then consumes an unbounded text stream over a valid/ready handshake. It reports each match position, a saturating match count, and its FSM state for the board display. It adds configurable symbol width, overlapping/non-overlapping counting and stop-at-first-match mode.

## Interface
- SYM_W, 8, symbol width in bits
- MAX_PAT, 8, maximum pattern length (≥2)
- CNT_W, 8, match counter width
- POS_W, 16, text position width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a search; honoured only in IDLE or DONE
- mode_overlap  in  1  1: overlapping matches counted; sampled at start
- mode_first  in  1  1: stop after first match; sampled at start
- pat_len  in  $clog2(MAX_PAT+1)  pattern length; sampled at start
- pat_wr  in  1  write pat_data to pattern slot pat_addr; honoured only in IDLE or DONE
- pat_addr  in  $clog2(MAX_PAT)  pattern slot index
- pat_data  in  SYM_W  pattern symbol
- txt_valid  in  1  text symbol present
- txt_data  in  SYM_W  text symbol
- txt_last  in  1  marks final text symbol
- txt_ready  out  1  symbol accepted when txt_valid && txt_ready
- match  out  1  one-cycle pulse per reported match
- match_pos  out  POS_W  start index (0-based, mod 2^POS_W) of last match
- match_count  out  CNT_W  matches this search, saturating
- busy  out  1  high in BUILD or SEARCH
- done  out  1  high in DONE
- err  out  1  invalid pat_len at last start
- state  out  4  IDLE=0, BUILD=1, SEARCH=2, DONE=3

## Operation
- **Reset:**
  - Outputs: state=IDLE; match, done, err, busy, txt_ready = 0; match_pos=0; match_count=0.
  - The pattern RAM and prefix table are not cleared.
  - Reset in any state, including mid-BUILD or mid-SEARCH, aborts and returns to IDLE.
- **start in IDLE/DONE:**
  - Samples pat_len and both modes; clears match_count, match_pos, err, text index, q and the hold register.
  - If pat_len==0 or pat_len>MAX_PAT: go to DONE with err=1.
  - Otherwise go to BUILD.
  - start in BUILD or SEARCH is ignored.
- **BUILD:** i=1, k=0, fail[0]=0. One step per cycle:
  - If i==pat_len: go to SEARCH.
  - Else if pat[i]==pat[k]: fail[i]=k+1, k++, i++.
  - Else if k>0: k=fail[k-1].
  - Else: fail[i]=0, i++.
- **SEARCH:**
  - Operand = hold if hold_valid, else txt_data.
  - txt_ready = (state==SEARCH) && !hold_valid.
  - Each cycle with an operand (hold_valid, or txt_valid&&txt_ready):
    - If pat[q]==operand: q++ and the symbol is consumed.
    - Else if q>0: q=fail[q-1]; the symbol is latched into hold (with its last flag), hold_valid=1, and it is retried next cycle.
    - Else: the symbol is consumed with q=0.
  - On consumption: hold_valid=0 and the text index increments.
  - When q reaches pat_len:
    - Pulse match.
    - match_pos = index_of_consumed_symbol − pat_len + 1.
    - match_count++, saturating at 2^CNT_W−1.
    - q = mode_overlap ? fail[pat_len−1] : 0.
    - If mode_first: go to DONE.
  - Consuming a symbol flagged last (after any match it completes): go to DONE.
- **DONE:** holds results until start or rst; pattern writes allowed.
- Symbol equality is full SYM_W-bit compare.

## Timing
- start sampled at edge t; state=BUILD from t+1.
- BUILD lasts between pat_len and 2·pat_len−1 cycles (pat_len=1: exactly 1).
- SEARCH throughput: one symbol per cycle while matching; each fallback costs one stall cycle with txt_ready=0.
- match, match_pos and match_count update on the edge that consumes the completing symbol; they are visible the following cycle.
- A match on the last symbol: match pulse and state=DONE are asserted in the same cycle.
- Text index and match_pos wrap modulo 2^POS_W.

## Test plan
- **Overlapping match:** pattern "ABAB", mode_overlap=1, text "ABABAB" (last on final B) -> two match pulses with match_pos 0 then 2; match_count=2; done=1.
- **Non-overlapping match:** same pattern and text, mode_overlap=0 -> one match pulse with match_pos=0; match_count=1.
- **Fallback stall:** pattern "AAB", text "AAAB" -> txt_ready low for exactly one cycle after the third A; one match pulse with match_pos=1; count=1.
- **First-match mode:** mode_first=1, pattern "A", text "XAAA" -> one match with match_pos=1; DONE; txt_ready=0 afterward; count=1.
- **Saturation and invalid length:**
  - CNT_W=2, pattern "A", text "AAAAA" -> five match pulses; match_count=3.
  - Next start with pat_len=0 -> DONE, err=1, count=0.
- **Reset mid-search:** rst asserted during SEARCH -> next cycle state=0, all outputs at reset values. A new start with pattern "AB" and text "AB" -> match_pos=0, count=1.

Source files
------------

// File: rtl/kmp_stream_matcher_if.sv
// Control, pattern-load and text-stream bundle for the KMP stream matcher.
// The master drives the controls and the text stream; the slave (matcher) returns status and match reports.
interface kmp_stream_matcher_if #(
  parameter int SYM_W   = 8,
  parameter int MAX_PAT = 8,
  parameter int CNT_W   = 8,
  parameter int POS_W   = 16
);
  localparam int PL_W = $clog2(MAX_PAT + 1);
  localparam int AD_W = $clog2(MAX_PAT);

  logic             start;
  logic             mode_overlap;
  logic             mode_first;
  logic [PL_W-1:0]  pat_len;
  logic             pat_wr;
  logic [AD_W-1:0]  pat_addr;
  logic [SYM_W-1:0] pat_data;
  logic             txt_valid;
  logic [SYM_W-1:0] txt_data;
  logic             txt_last;
  logic             txt_ready;
  logic             match;
  logic [POS_W-1:0] match_pos;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic             err;
  logic [3:0]       state;

  modport master (
    output start, mode_overlap, mode_first, pat_len, pat_wr, pat_addr, pat_data,
           txt_valid, txt_data, txt_last,
    input  txt_ready, match, match_pos, match_count, busy, done, err, state
  );

  modport slave (
    input  start, mode_overlap, mode_first, pat_len, pat_wr, pat_addr, pat_data,
           txt_valid, txt_data, txt_last,
    output txt_ready, match, match_pos, match_count, busy, done, err, state
  );
endinterface

// File: rtl/kmp_stream_matcher.sv
// KMP search engine: builds the failure table in pat_len..2*pat_len-1 cycles, then scans one symbol per cycle;
// match results appear the cycle after the completing symbol; each fallback stalls txt_ready for one cycle.
module kmp_stream_matcher #(
  parameter int SYM_W   = 8,
  parameter int MAX_PAT = 8,
  parameter int CNT_W   = 8,
  parameter int POS_W   = 16
) (
  input logic               clk,
  input logic               rst,
  kmp_stream_matcher_if.slave bus
);
  localparam int PL_W = $clog2(MAX_PAT + 1);
  localparam int AD_W = $clog2(MAX_PAT);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    BUILD  = 4'd1,
    SEARCH = 4'd2,
    DONE   = 4'd3
  } state_t;

  state_t st, st_n;

  logic [SYM_W-1:0] pat_mem  [MAX_PAT];
  logic [PL_W-1:0]  fail_mem [MAX_PAT];

  logic [PL_W-1:0]  plen_r, plen_n, i_r, i_n, k_r, k_n, q_r, q_n;
  logic             ov_r, ov_n, fi_r, fi_n;
  logic             hold_vld, hold_vld_n, hold_last, hold_last_n;
  logic [SYM_W-1:0] hold_dat, hold_dat_n;
  logic [POS_W-1:0] idx_r, idx_n, pos_r, pos_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             match_r, match_n, err_r, err_n;

  logic             fail_we;
  logic [AD_W-1:0]  fail_wa;
  logic [PL_W-1:0]  fail_wd;

  logic             txt_rdy, op_vld, op_last, consume;
  logic [SYM_W-1:0] op;
  logic [PL_W-1:0]  q_adv;

  assign txt_rdy = (st == SEARCH) && !hold_vld;
  assign op_vld  = hold_vld || (bus.txt_valid && txt_rdy);
  assign op      = hold_vld ? hold_dat  : bus.txt_data;
  assign op_last = hold_vld ? hold_last : bus.txt_last;

  always_comb begin
    st_n        = st;
    plen_n      = plen_r;
    i_n         = i_r;
    k_n         = k_r;
    q_n         = q_r;
    ov_n        = ov_r;
    fi_n        = fi_r;
    hold_vld_n  = hold_vld;
    hold_last_n = hold_last;
    hold_dat_n  = hold_dat;
    idx_n       = idx_r;
    pos_n       = pos_r;
    cnt_n       = cnt_r;
    err_n       = err_r;
    match_n     = 1'b0;
    fail_we     = 1'b0;
    fail_wa     = '0;
    fail_wd     = '0;
    consume     = 1'b0;
    q_adv       = '0;

    case (st)
      IDLE, DONE: begin
        if (bus.start) begin
          plen_n     = bus.pat_len;
          ov_n       = bus.mode_overlap;
          fi_n       = bus.mode_first;
          cnt_n      = '0;
          pos_n      = '0;
          err_n      = 1'b0;
          idx_n      = '0;
          q_n        = '0;
          hold_vld_n = 1'b0;
          i_n        = PL_W'(1);
          k_n        = '0;
          fail_we    = 1'b1;
          if (bus.pat_len == '0 || bus.pat_len > PL_W'(MAX_PAT)) begin
            err_n = 1'b1;
            st_n  = DONE;
          end else begin
            st_n  = BUILD;
          end
        end
      end

      BUILD: begin
        if (i_r == plen_r) begin
          st_n = SEARCH;
        end else if (pat_mem[AD_W'(i_r)] == pat_mem[AD_W'(k_r)]) begin
          fail_we = 1'b1;
          fail_wa = AD_W'(i_r);
          fail_wd = k_r + PL_W'(1);
          k_n     = k_r + PL_W'(1);
          i_n     = i_r + PL_W'(1);
        end else if (k_r != '0) begin
          k_n = fail_mem[AD_W'(k_r - PL_W'(1))];
        end else begin
          fail_we = 1'b1;
          fail_wa = AD_W'(i_r);
          i_n     = i_r + PL_W'(1);
        end
      end

      SEARCH: begin
        if (op_vld) begin
          if (pat_mem[AD_W'(q_r)] == op) begin
            consume = 1'b1;
            q_adv   = q_r + PL_W'(1);
          end else if (q_r != '0) begin
            // Retry the same symbol against the shorter border next cycle.
            q_n         = fail_mem[AD_W'(q_r - PL_W'(1))];
            hold_vld_n  = 1'b1;
            hold_dat_n  = op;
            hold_last_n = op_last;
          end else begin
            consume = 1'b1;
          end

          if (consume) begin
            q_n        = q_adv;
            hold_vld_n = 1'b0;
            idx_n      = idx_r + POS_W'(1);
            if (q_adv == plen_r) begin
              match_n = 1'b1;
              pos_n   = idx_r - POS_W'(plen_r) + POS_W'(1);
              if (cnt_r != '1)
                cnt_n = cnt_r + CNT_W'(1);
              q_n = ov_r ? fail_mem[AD_W'(plen_r - PL_W'(1))] : '0;
              if (fi_r)
                st_n = DONE;
            end
            if (op_last)
              st_n = DONE;
          end
        end
      end

      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      st <= IDLE;
    else
      st <= st_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      plen_r    <= '0;
      i_r       <= '0;
      k_r       <= '0;
      q_r       <= '0;
      ov_r      <= 1'b0;
      fi_r      <= 1'b0;
      hold_vld  <= 1'b0;
      hold_last <= 1'b0;
      hold_dat  <= '0;
      idx_r     <= '0;
      pos_r     <= '0;
      cnt_r     <= '0;
      match_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      plen_r    <= plen_n;
      i_r       <= i_n;
      k_r       <= k_n;
      q_r       <= q_n;
      ov_r      <= ov_n;
      fi_r      <= fi_n;
      hold_vld  <= hold_vld_n;
      hold_last <= hold_last_n;
      hold_dat  <= hold_dat_n;
      idx_r     <= idx_n;
      pos_r     <= pos_n;
      cnt_r     <= cnt_n;
      match_r   <= match_n;
      err_r     <= err_n;
    end
  end

  // Pattern and failure tables survive reset; only their write enables are gated.
  always_ff @(posedge clk) begin
    if (bus.pat_wr && (st == IDLE || st == DONE) && int'(bus.pat_addr) < MAX_PAT)
      pat_mem[bus.pat_addr] <= bus.pat_data;
  end

  always_ff @(posedge clk) begin
    if (fail_we && !rst)
      fail_mem[fail_wa] <= fail_wd;
  end

  assign bus.txt_ready   = txt_rdy;
  assign bus.match       = match_r;
  assign bus.match_pos   = pos_r;
  assign bus.match_count = cnt_r;
  assign bus.busy        = (st == BUILD) || (st == SEARCH);
  assign bus.done        = (st == DONE);
  assign bus.err         = err_r;
  assign bus.state       = st;
endmodule

// File: tb/tb_kmp_stream_matcher.sv
// Directed-vector bench for kmp_stream_matcher: a table of searches with hand-computed results,
// plus hand-written reset sequences.
module tb_kmp_stream_matcher;
  localparam int SYM_W   = 8;
  localparam int MAX_PAT = 8;
  localparam int CNT_W   = 2;
  localparam int POS_W   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kmp_stream_matcher_if #(.SYM_W(SYM_W), .MAX_PAT(MAX_PAT), .CNT_W(CNT_W), .POS_W(POS_W)) bus ();

  kmp_stream_matcher #(.SYM_W(SYM_W), .MAX_PAT(MAX_PAT), .CNT_W(CNT_W), .POS_W(POS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [63:0]  pat;
    int           pat_n;
    logic [3:0]   plen;
    logic         ov;
    logic         fi;
    logic [127:0] txt;
    int           tlen;
    int           e_pulses;
    int           e_first;
    int           e_final;
    int           e_count;
    logic         e_err;
    int           e_stalls;
    int           e_build;
  } vec_t;

  vec_t tv[11];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " state"},       int'(bus.state), 0);
    chk({tag, " match"},       int'(bus.match), 0);
    chk({tag, " busy"},        int'(bus.busy), 0);
    chk({tag, " done"},        int'(bus.done), 0);
    chk({tag, " err"},         int'(bus.err), 0);
    chk({tag, " txt_ready"},   int'(bus.txt_ready), 0);
    chk({tag, " match_pos"},   int'(bus.match_pos), 0);
    chk({tag, " match_count"}, int'(bus.match_count), 0);
  endtask

  task automatic run_case(input int c, input vec_t v);
    int pulses, first, stalls, builds, ti, cyc;
    logic acc;
    for (int j = 0; j < v.pat_n; j++) begin
      bus.pat_wr   = 1'b1;
      bus.pat_addr = 3'(j);
      bus.pat_data = v.pat[8*(v.pat_n-1-j) +: 8];
      tick();
    end
    bus.pat_wr       = 1'b0;
    bus.start        = 1'b1;
    bus.pat_len      = v.plen;
    bus.mode_overlap = v.ov;
    bus.mode_first   = v.fi;
    tick();
    bus.start = 1'b0;
    chk($sformatf("c%0d state_after_start", c), int'(bus.state), v.e_err ? 3 : 1);

    pulses = 0; first = -1; stalls = 0; ti = 0; cyc = 0;
    builds = (bus.state == 4'd1) ? 1 : 0;
    if (v.tlen > 0) begin
      bus.txt_valid = 1'b1;
      bus.txt_data  = v.txt[8*(v.tlen-1) +: 8];
      bus.txt_last  = (v.tlen == 1);
    end
    while (!bus.done && cyc < 200) begin
      acc = bus.txt_valid && bus.txt_ready;
      tick();
      cyc++;
      if (acc) begin
        ti++;
        if (ti < v.tlen) begin
          bus.txt_data = v.txt[8*(v.tlen-1-ti) +: 8];
          bus.txt_last = (ti == v.tlen - 1);
        end else begin
          bus.txt_valid = 1'b0;
          bus.txt_last  = 1'b0;
        end
      end
      if (bus.match) begin
        pulses++;
        if (first < 0) first = int'(bus.match_pos);
      end
      if (bus.state == 4'd1) builds++;
      if (bus.state == 4'd2 && !bus.txt_ready) stalls++;
    end
    bus.txt_valid = 1'b0;
    bus.txt_last  = 1'b0;

    chk($sformatf("c%0d done", c),        int'(bus.done), 1);
    chk($sformatf("c%0d pulses", c),      pulses, v.e_pulses);
    chk($sformatf("c%0d first_pos", c),   first, v.e_first);
    chk($sformatf("c%0d match_pos", c),   int'(bus.match_pos), v.e_final);
    chk($sformatf("c%0d match_count", c), int'(bus.match_count), v.e_count);
    chk($sformatf("c%0d err", c),         int'(bus.err), int'(v.e_err));
    chk($sformatf("c%0d stalls", c),      stalls, v.e_stalls);
    chk($sformatf("c%0d build_cycles", c), builds, v.e_build);
    chk($sformatf("c%0d busy", c),        int'(bus.busy), 0);
    chk($sformatf("c%0d txt_ready", c),   int'(bus.txt_ready), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int cnt_before;
    //                pat               n  plen  ov    fi    txt                          tlen pul first fin cnt err   stl bld
    tv[0]  = '{64'("ABAB"), 4, 4'd4, 1'b1, 1'b0, 128'("ABABAB"),               6, 2,  0,  2, 2, 1'b0, 0, 4};
    tv[1]  = '{64'("ABAB"), 4, 4'd4, 1'b0, 1'b0, 128'("ABABAB"),               6, 1,  0,  0, 1, 1'b0, 0, 4};
    tv[2]  = '{64'("AAB"),  3, 4'd3, 1'b0, 1'b0, 128'("AAAB"),                 4, 1,  1,  1, 1, 1'b0, 1, 4};
    tv[3]  = '{64'("A"),    1, 4'd1, 1'b0, 1'b1, 128'("XAAA"),                 4, 1,  1,  1, 1, 1'b0, 0, 1};
    tv[4]  = '{64'("A"),    1, 4'd1, 1'b1, 1'b0, 128'("AAAAA"),                5, 5,  0,  4, 3, 1'b0, 0, 1};
    tv[5]  = '{64'(0),      0, 4'd0, 1'b0, 1'b0, 128'(0),                      0, 0, -1,  0, 0, 1'b1, 0, 0};
    tv[6]  = '{64'(0),      0, 4'd9, 1'b0, 1'b0, 128'(0),                      0, 0, -1,  0, 0, 1'b1, 0, 0};
    tv[7]  = '{64'("A"),    1, 4'd1, 1'b0, 1'b0, 128'({8'hC1, 8'h41}),         2, 1,  1,  1, 1, 1'b0, 0, 1};
    tv[8]  = '{64'("ABAC"), 4, 4'd4, 1'b0, 1'b0, 128'("ABABAC"),               6, 1,  2,  2, 1, 1'b0, 1, 5};
    tv[9]  = '{64'("AB"),   2, 4'd2, 1'b0, 1'b0, 128'("AA"),                   2, 0, -1,  0, 0, 1'b0, 1, 2};
    tv[10] = '{64'("AB"),   2, 4'd2, 1'b0, 1'b0, 128'("AB"),                   2, 1,  0,  0, 1, 1'b0, 0, 2};

    rst = 1'b1;
    bus.start = 1'b0; bus.mode_overlap = 1'b0; bus.mode_first = 1'b0; bus.pat_len = '0;
    bus.pat_wr = 1'b0; bus.pat_addr = '0; bus.pat_data = '0;
    bus.txt_valid = 1'b0; bus.txt_data = '0; bus.txt_last = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    for (int c = 0; c < 10; c++)
      run_case(c, tv[c]);

    // Abort a live search with matches already counted.
    bus.pat_wr = 1'b1; bus.pat_addr = '0; bus.pat_data = 8'h41;
    tick();
    bus.pat_wr = 1'b0;
    bus.start = 1'b1; bus.pat_len = 4'd1; bus.mode_overlap = 1'b0; bus.mode_first = 1'b0;
    tick();
    bus.start = 1'b0;
    bus.txt_valid = 1'b1; bus.txt_data = 8'h41; bus.txt_last = 1'b0;
    cyc = 0;
    while (!bus.match && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    cnt_before = int'(bus.match_count);
    chk("midsearch state", int'(bus.state), 2);
    chk("midsearch count_nonzero", int'(cnt_before != 0), 1);
    rst = 1'b1;
    tick();
    bus.txt_valid = 1'b0;
    check_reset_outputs("midrst");
    rst = 1'b0;
    tick();

    run_case(10, tv[10]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
